// File: rtl/btn_tx_scheduler.sv
// Debounces synchronized buttons into sticky press requests and serves them
// round-robin onto a single UART TX port, one byte (CODE_BASE + index) per press.
module btn_tx_scheduler #(
  parameter int         N_BTN       = 4,
  parameter int         HOLD_CYCLES = 1_000_000,
  parameter logic [7:0] CODE_BASE   = 8'h41
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_sync,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [N_BTN-1:0] pending,
  output logic [2:0]       active_idx
);

  localparam int             CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [1:0]     IDLE      = 2'd0;
  localparam logic [1:0]     START     = 2'd1;
  localparam logic [1:0]     WAIT_DONE = 2'd2;

  logic [CW-1:0]    cnt [N_BTN];
  logic [N_BTN-1:0] filt;
  logic [N_BTN-1:0] filt_d;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] clr;
  logic [1:0]       state;
  logic [2:0]       rr_ptr;
  logic [2:0]       rr_next;
  logic [2:0]       grant_idx;
  logic [2:0]       cand;
  logic [7:0]       pend_ext;
  logic             grant_vld;
  logic             grant;

  // Stable-time filter: a level is accepted only after HOLD_CYCLES unchanged samples
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      filt   <= '0;
      filt_d <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      filt_d <= filt;
      for (int i = 0; i < N_BTN; i++) begin
        if (btn_sync[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= btn_sync[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press = filt & ~filt_d;

  // Descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    pend_ext  = 8'(pending);
    for (int k = N_BTN - 1; k >= 0; k--) begin
      cand = 3'((int'(rr_ptr) + k) % N_BTN);
      if (pend_ext[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign rr_next = (grant_idx == 3'(N_BTN - 1)) ? 3'd0 : grant_idx + 3'd1;
  assign grant   = (state == IDLE) && grant_vld && !tx_busy;

  always_comb begin
    clr = '0;
    if (grant) clr = N_BTN'(8'b1 << grant_idx);
  end

  // A press landing on the same edge as its grant survives (set wins over clear)
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= (pending & ~clr) | press;
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      active_idx <= '0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            tx_data    <= CODE_BASE + {5'd0, grant_idx};
            active_idx <= grant_idx;
            rr_ptr     <= rr_next;
            tx_start   <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (tx_busy) begin
            tx_start <= 1'b0;
            state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          tx_start <= 1'b0;
          if (!tx_busy) state <= IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_tx_scheduler.sv
// Bench for btn_tx_scheduler: directed vector table, multi-cycle corner sequences
// and randomized press rounds checked against a transaction-level round-robin model.
module tb_btn_tx_scheduler;

  localparam int N_BTN    = 4;
  localparam int HOLD     = 4;
  localparam int BUSY_LEN = 10;

  logic       clk_100MHz = 1'b0;
  logic       reset_n    = 1'b0;
  logic [3:0] btn_sync   = '0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] pending;
  logic [2:0] active_idx;

  btn_tx_scheduler #(
    .N_BTN(N_BTN), .HOLD_CYCLES(HOLD), .CODE_BASE(8'h41)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .btn_sync(btn_sync), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .pending(pending), .active_idx(active_idx)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] idx;
  } tx_t;

  typedef struct {
    logic [3:0]      btn;
    int              hold;
    int              n;
    logic [3:0][7:0] b;
  } vec_t;

  tx_t got[$];
  int  busy_cnt = 0;
  int  n_pass   = 0;
  int  n_total  = 0;
  logic prev_start = 1'b0;

  assign tx_busy = (busy_cnt != 0);

  // UART TX model: busy one cycle after a start is seen, for BUSY_LEN cycles
  always @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else if (tx_start) begin
      busy_cnt <= BUSY_LEN;
      got.push_back('{data: tx_data, idx: active_idx});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Every new start request must be issued only while the transmitter is idle
  always @(negedge clk_100MHz) begin
    if (tx_start && !prev_start) check("start_while_idle", 32'(tx_busy), 32'd0);
    prev_start <= tx_start;
  end

  function automatic vec_t mk(input logic [3:0] btn, input int hold, input int n,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    vec_t v;
    v.btn = btn; v.hold = hold; v.n = n;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    int   found;
    int   quiet;
    int   mrr;
    int   last;
    logic [3:0] mask;
    logic [3:0] gl;
    int   glen;
    int   hold;
    logic [7:0] exp_b[$];
    int   exp_i[$];

    // Round-robin pointer starts at 0 after reset; expectations follow that order
    vecs[0] = mk(4'b1011, 10, 3, 8'h41, 8'h42, 8'h44, 8'h00);
    vecs[1] = mk(4'b0001,  3, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[2] = mk(4'b0100, 20, 1, 8'h43, 8'h00, 8'h00, 8'h00);
    vecs[3] = mk(4'b0011,  8, 2, 8'h41, 8'h42, 8'h00, 8'h00);
    vecs[4] = mk(4'b1111,  4, 4, 8'h43, 8'h44, 8'h41, 8'h42);
    vecs[5] = mk(4'b0010,  3, 0, 8'h00, 8'h00, 8'h00, 8'h00);

    repeat (3) @(negedge clk_100MHz);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_active_idx", 32'(active_idx), 32'd0);
    reset_n = 1'b1;

    foreach (vecs[v]) begin
      got.delete();
      btn_sync = vecs[v].btn;
      repeat (vecs[v].hold) @(negedge clk_100MHz);
      btn_sync = '0;
      repeat (150) @(negedge clk_100MHz);
      check($sformatf("vec%0d_count", v), 32'(got.size()), 32'(vecs[v].n));
      for (int k = 0; k < vecs[v].n && k < got.size(); k++) begin
        check($sformatf("vec%0d_byte%0d", v, k), 32'(got[k].data), 32'(vecs[v].b[k]));
        check($sformatf("vec%0d_idx%0d", v, k), 32'(got[k].idx), 32'(vecs[v].b[k] - 8'h41));
      end
    end

    // Single press: pending rises on the 5th edge after the input rises
    got.delete();
    btn_sync = 4'b0100;
    repeat (4) @(negedge clk_100MHz);
    check("t1_pending_early", 32'(pending), 32'd0);
    @(negedge clk_100MHz);
    check("t1_pending_set", 32'(pending), 32'b0100);
    @(negedge clk_100MHz);
    check("t1_tx_start", 32'(tx_start), 32'd1);
    check("t1_tx_data", 32'(tx_data), 32'h43);
    check("t1_active_idx", 32'(active_idx), 32'd2);
    check("t1_pending_clr", 32'(pending), 32'd0);
    repeat (14) @(negedge clk_100MHz);
    btn_sync = '0;
    repeat (60) @(negedge clk_100MHz);
    check("t1_count", 32'(got.size()), 32'd1);

    // Re-press of button 3 while its first byte is still on the wire
    got.delete();
    btn_sync = 4'b1000;
    repeat (5) @(negedge clk_100MHz);
    btn_sync = '0;
    repeat (5) @(negedge clk_100MHz);
    btn_sync = 4'b1000;
    repeat (5) @(negedge clk_100MHz);
    check("t5_repending", 32'(pending), 32'b1000);
    check("t5_busy_during", 32'(tx_busy), 32'd1);
    btn_sync = '0;
    repeat (100) @(negedge clk_100MHz);
    check("t5_count", 32'(got.size()), 32'd2);
    for (int k = 0; k < got.size() && k < 2; k++)
      check($sformatf("t5_byte%0d", k), 32'(got[k].data), 32'h44);

    // Buttons 0 and 1 pressed together repeatedly: grants must alternate
    got.delete();
    for (int p = 0; p < 12; p++) begin
      btn_sync = 4'b0011;
      repeat (10) @(negedge clk_100MHz);
      btn_sync = '0;
      repeat (10) @(negedge clk_100MHz);
    end
    repeat (100) @(negedge clk_100MHz);
    check("t4_enough_grants", 32'(got.size() >= 8), 32'd1);
    for (int k = 0; k < got.size(); k++) begin
      check($sformatf("t4_idx_range%0d", k), 32'(got[k].idx < 3'd2), 32'd1);
      check($sformatf("t4_code%0d", k), 32'(got[k].data), 32'(8'h41 + {5'd0, got[k].idx}));
      if (k > 0)
        check($sformatf("t4_alternate%0d", k), 32'(got[k].idx != got[k-1].idx), 32'd1);
    end

    // Async reset while a start request is outstanding and another press is queued
    got.delete();
    btn_sync = 4'b0110;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk_100MHz);
      if (tx_start) found = 1;
    end
    check("t6_start_seen", 32'(found), 32'd1);
    check("t6_other_pending", 32'(pending != 4'd0), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("t6_tx_start_drop", 32'(tx_start), 32'd0);
    check("t6_pending_clr", 32'(pending), 32'd0);
    check("t6_tx_data_clr", 32'(tx_data), 32'h00);
    check("t6_active_clr", 32'(active_idx), 32'd0);
    btn_sync = '0;
    repeat (3) @(negedge clk_100MHz);
    reset_n = 1'b1;
    got.delete();
    quiet = 0;
    repeat (100) begin
      @(negedge clk_100MHz);
      if (tx_start) quiet++;
    end
    check("t6_quiet_cycles", 32'(quiet), 32'd0);
    check("t6_no_bytes", 32'(got.size()), 32'd0);

    // Random rounds: simultaneous presses plus sub-threshold glitches on other buttons
    mrr = 0;
    for (int r = 0; r < 20; r++) begin
      mask = 4'($urandom_range(0, 15));
      gl   = 4'($urandom_range(0, 15)) & ~mask;
      glen = int'($urandom_range(1, HOLD - 1));
      hold = int'($urandom_range(HOLD, 12));
      got.delete();
      exp_b.delete();
      exp_i.delete();
      last = -1;
      for (int k = 0; k < N_BTN; k++) begin
        int j;
        j = (mrr + k) % N_BTN;
        if (mask[j]) begin
          exp_b.push_back(8'h41 + 8'(j));
          exp_i.push_back(j);
          last = j;
        end
      end
      if (last >= 0) mrr = (last + 1) % N_BTN;

      btn_sync = mask | gl;
      for (int c = 1; c <= hold; c++) begin
        @(negedge clk_100MHz);
        if (c == glen) btn_sync = btn_sync & ~gl;
      end
      btn_sync = '0;
      repeat (120) @(negedge clk_100MHz);
      check($sformatf("rnd%0d_count", r), 32'(got.size()), 32'(exp_b.size()));
      for (int k = 0; k < exp_b.size() && k < got.size(); k++) begin
        check($sformatf("rnd%0d_byte%0d", r, k), 32'(got[k].data), 32'(exp_b[k]));
        check($sformatf("rnd%0d_idx%0d", r, k), 32'(got[k].idx), 32'(exp_i[k]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
